// File: rtl/multdiv_issue_ctrl.sv
//==============================================================================
// Module      : multdiv_issue_ctrl
// Description : Issue controller between the execute stage and a multi-cycle
//               multiply/divide unit. Accepts one request, launches the unit
//               with a single-cycle control pulse, waits (bounded) for the
//               result and hands it to writeback, substituting exception or
//               abort codes where needed.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module multdiv_issue_ctrl #(
    parameter int          TIMEOUT       = 48,
    parameter logic [4:0]  RSTATUS_REG   = 5'd30,
    parameter logic [31:0] MULT_EXC_CODE = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
    input  logic        clock,
    input  logic        reset,
    // execute-stage request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    // downstream multdiv unit
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    // writeback
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exc,
    // status
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LAUNCH = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_WB     = 2'd3;

    // Counter value seen in the last WAIT cycle that may still capture; the
    // counter is cleared in LAUNCH so WAIT cycle k sees k-1. Limits beyond the
    // 6-bit range are capped at the saturation value.
    localparam int         c_LAST_INT  = (TIMEOUT > 64) ? 63 : ((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    localparam logic [5:0] c_WAIT_LAST = 6'(c_LAST_INT);
    localparam logic [5:0] c_CNT_MAX   = 6'h3F;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [5:0]  r_count;
    logic        r_op;
    logic [4:0]  r_rd;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_exc;
    logic        r_timeout_err;

    logic w_accept;
    logic w_capture;
    logic w_wait_expired;
    logic w_abort;

    assign w_accept       = (r_state == c_IDLE) && req_valid;
    assign w_capture      = (r_state == c_WAIT) && md_resultRDY;
    assign w_wait_expired = (r_count >= c_WAIT_LAST);
    // A result arriving in the final WAIT cycle wins over the abort.
    assign w_abort        = (r_state == c_WAIT) && !md_resultRDY && w_wait_expired;

    // Next-state selection for the issue sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (req_valid) w_state_next = c_LAUNCH;
            c_LAUNCH: w_state_next = c_WAIT;
            c_WAIT:   if (md_resultRDY || w_wait_expired) w_state_next = c_WB;
            c_WB:     if (wb_ready) w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= c_IDLE;
        else        r_state <= w_state_next;
    end

    // Wait counter: cleared at launch, saturating increment while waiting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= 6'd0;
        end else if (r_state == c_LAUNCH) begin
            r_count <= 6'd0;
        end else if ((r_state == c_WAIT) && (r_count != c_CNT_MAX)) begin
            r_count <= r_count + 6'd1;
        end
    end

    // Request latch and writeback payload capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_op      <= 1'b0;
            r_rd      <= 5'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
            r_wb_exc  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= req_op;
                r_rd <= req_rd;
                r_a  <= req_a;
                r_b  <= req_b;
            end
            if (w_capture) begin
                if (md_exception) begin
                    r_wb_rd   <= RSTATUS_REG;
                    r_wb_data <= r_op ? DIV_EXC_CODE : MULT_EXC_CODE;
                    r_wb_exc  <= 1'b1;
                end else begin
                    r_wb_rd   <= r_rd;
                    r_wb_data <= md_result;
                    r_wb_exc  <= 1'b0;
                end
            end else if (w_abort) begin
                r_wb_rd   <= 5'd0;
                r_wb_data <= 32'd0;
                r_wb_exc  <= 1'b1;
            end
        end
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!reset)       r_timeout_err <= 1'b0;
        else if (w_abort) r_timeout_err <= 1'b1;
    end

    assign req_ready    = (r_state == c_IDLE);
    assign busy         = (r_state != c_IDLE);
    assign md_ctrl_MULT = (r_state == c_LAUNCH) && !r_op;
    assign md_ctrl_DIV  = (r_state == c_LAUNCH) && r_op;
    assign md_operandA  = r_a;
    assign md_operandB  = r_b;
    assign wb_valid     = (r_state == c_WB);
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_exc       = r_wb_exc;
    assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
//==============================================================================
// Module      : tb_multdiv_issue_ctrl
// Description : Self-checking bench for multdiv_issue_ctrl. A driver issues
//               requests and queues expected writebacks, a behavioural multdiv
//               unit answers launches after a planned delay, and a monitor
//               compares every writeback against the queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multdiv_issue_ctrl;

    localparam int TIMEOUT = 48;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic        to;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        int          delay;
    } plan_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exc;
    logic        busy;
    logic        timeout_err;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    failures = 0;
    int    wb_count = 0;
    bit    md_busy = 1'b0;
    bit    exp_sticky = 1'b0;
    int    hold = 0;
    bit    release_next = 1'b0;
    bit    expect_idle = 1'b0;

    always #5 clock = ~clock;

    multdiv_issue_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exc(wb_exc), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Behaviour of the multdiv unit: signed 32x32 multiply (overflow of the
    // signed 32-bit range raises an exception), signed divide (zero divisor
    // raises an exception).
    function automatic bit unit_exc(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (op) return (b == 32'd0);
        p = longint'($signed(a)) * longint'($signed(b));
        return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] unit_result(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint q;
        if (op) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            q = longint'($signed(a)) / longint'($signed(b));
        end else begin
            q = longint'($signed(a)) * longint'($signed(b));
        end
        return q[31:0];
    endfunction

    task automatic check_reset_vals();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_exc", wb_exc, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_md_ctrl_MULT", md_ctrl_MULT, 0);
        chk("rst_md_ctrl_DIV", md_ctrl_DIV, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_md_operandA", md_operandA, 0);
        chk("rst_md_operandB", md_operandB, 0);
    endtask

    // Issue one request. With expect_wb clear the task returns in the launch
    // cycle so the caller can disturb the operation.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int delay, input bit expect_wb);
        exp_t  e;
        plan_t p;
        int    n;
        int    start_wb;
        p.op = op; p.a = a; p.b = b; p.delay = delay;
        plan_q.push_back(p);
        if (expect_wb) begin
            if (delay > TIMEOUT) begin
                e.rd = 5'd0; e.data = 32'd0; e.exc = 1'b1; e.to = 1'b1;
            end else if (unit_exc(op, a, b)) begin
                e.rd = 5'd30; e.data = op ? 32'd5 : 32'd4; e.exc = 1'b1; e.to = 1'b0;
            end else begin
                e.rd = rd; e.data = unit_result(op, a, b); e.exc = 1'b0; e.to = 1'b0;
            end
            exp_q.push_back(e);
        end
        start_wb = wb_count;
        @(negedge clock);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) chk("req_accept_bound", 0, 1);
        @(negedge clock);
        // Launch cycle: scramble the live request so only latched values matter.
        req_valid = 1'b0; req_op = ~op; req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
        if (!expect_wb) return;
        n = 0;
        while (!wb_valid && n < 200) begin
            @(negedge clock);
            n++;
            chk("operandA_held", md_operandA, a);
            chk("operandB_held", md_operandB, b);
        end
        chk("wb_latency", n, (delay > TIMEOUT) ? TIMEOUT + 1 : delay + 1);
        n = 0;
        while (wb_count == start_wb && n < 200) begin
            if (busy) begin
                chk("operandA_held_wb", md_operandA, a);
                chk("operandB_held_wb", md_operandB, b);
            end
            @(negedge clock);
            n++;
        end
        if (wb_count == start_wb) chk("wb_handshake_bound", 0, 1);
        n = 0;
        while (md_busy && n < 200) begin
            @(negedge clock);
            n++;
        end
    endtask

    // Behavioural multdiv unit: answers each launch after the planned delay.
    initial begin
        plan_t p;
        md_resultRDY = 1'b0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        forever begin
            @(negedge clock);
            md_result    = $urandom;
            md_exception = 1'($urandom_range(0, 1));
            if (reset && (md_ctrl_MULT || md_ctrl_DIV)) begin
                chk("ctrl_not_both", {31'd0, md_ctrl_MULT & md_ctrl_DIV}, 0);
                if (plan_q.size() == 0) begin
                    chk("ctrl_unplanned", 1, 0);
                end else begin
                    p = plan_q.pop_front();
                    chk("ctrl_kind", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, p.op ? 32'd1 : 32'd2);
                    md_busy = 1'b1;
                    for (int i = 1; i <= p.delay; i++) begin
                        @(negedge clock);
                        if (i == 1) chk("ctrl_pulse_width", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 0);
                        if (i == p.delay) begin
                            md_resultRDY = 1'b1;
                            md_result    = unit_result(p.op, p.a, p.b);
                            md_exception = unit_exc(p.op, p.a, p.b);
                        end else begin
                            md_result    = $urandom;
                            md_exception = 1'($urandom_range(0, 1));
                        end
                    end
                    @(negedge clock);
                    md_resultRDY = 1'b0;
                    md_result    = $urandom;
                    md_busy      = 1'b0;
                end
            end
        end
    end

    // Writeback monitor: compares against the expected queue, drives wb_ready.
    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset) begin
            expect_idle = 1'b0;
            wb_ready    = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("idle_after_wb", {30'd0, req_ready, busy}, 32'd2);
                expect_idle = 1'b0;
            end
            if (wb_valid) begin
                chk("wb_req_ready_low", req_ready, 0);
                chk("wb_no_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                    chk("wb_exc", wb_exc, e.exc);
                    if (hold > 0) begin
                        wb_ready = 1'b0;
                        hold--;
                        release_next = 1'b1;
                    end else if (release_next) begin
                        wb_ready = 1'b1;
                        release_next = 1'b0;
                    end else begin
                        wb_ready = ($urandom_range(0, 9) < 7);
                    end
                    if (wb_ready) begin
                        void'(exp_q.pop_front());
                        if (e.to) exp_sticky = 1'b1;
                        chk("timeout_err", timeout_err, exp_sticky);
                        wb_count++;
                        expect_idle = 1'b1;
                    end
                end
            end else begin
                wb_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        logic        rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rdly;
        int          sel;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals();
        reset = 1'b1;

        run_op(1'b0, 32'd7, -32'sd3, 5'd9, 3, 1'b1);
        run_op(1'b1, 32'd20, -32'sd3, 5'd4, 5, 1'b1);
        run_op(1'b1, 32'h8000_0000, 32'd7, 5'd17, 30, 1'b1);
        run_op(1'b1, 32'd123, 32'd0, 5'd8, 2, 1'b1);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd5, 4, 1'b1);
        hold = 10;
        run_op(1'b0, 32'd5, 32'd6, 5'd3, 2, 1'b1);
        run_op(1'b0, 32'd1, 32'd2, 5'd6, TIMEOUT, 1'b1);
        chk("no_timeout_at_limit", timeout_err, 0);
        run_op(1'b1, 32'd9, 32'd3, 5'd7, 60, 1'b1);
        chk("timeout_sticky", timeout_err, 1);
        run_op(1'b0, 32'd11, 32'd12, 5'd21, 1, 1'b1);

        for (int t = 0; t < 25; t++) begin
            rop = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                ra = 32'($urandom_range(0, 400)) - 32'd200;
                rb = 32'($urandom_range(0, 400)) - 32'd200;
            end else if (sel < 8) begin
                ra = $urandom;
                rb = $urandom;
            end else begin
                ra = $urandom;
                rb = 32'd0;
            end
            rdly = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 12) : $urandom_range(46, 52);
            run_op(rop, ra, rb, 5'($urandom_range(1, 31)), rdly, 1'b1);
        end

        // Abort in WAIT cycle 10; the late result must go nowhere.
        run_op(1'b1, 32'd100, 32'd7, 5'd12, 20, 1'b0);
        repeat (10) @(negedge clock);
        chk("busy_before_abort", busy, 1);
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals();
        exp_sticky = 1'b0;
        reset = 1'b1;
        repeat (25) @(negedge clock);
        chk("idle_after_abort", busy, 0);
        run_op(1'b0, 32'd3, 32'd4, 5'd2, 6, 1'b1);

        repeat (3) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multdiv_issue_ctrl.md
MULTDIV_ISSUE_CTRL -- requirements
Module: multdiv_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 48: max WAIT cycles before abort.
REQ-002 Parameter RSTATUS_REG, default 30: destination register for exception codes.
REQ-003 Parameters MULT_EXC_CODE = 4 and DIV_EXC_CODE = 5: rstatus values written on exception.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clock  in  1  sole clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 req_valid  in  1; req_ready  out  1: execute-stage request handshake.
REQ-008 req_op  in  1  0 = multiply, 1 = divide; req_a, req_b  in  32  operands; req_rd  in  5  destination register.
REQ-009 md_operandA, md_operandB  out  32; md_ctrl_MULT, md_ctrl_DIV  out  1: drive the downstream multdiv unit.
REQ-010 md_result  in  32; md_exception  in  1; md_resultRDY  in  1: returned by multdiv.
REQ-011 wb_valid  out  1; wb_ready  in  1; wb_rd  out  5; wb_data  out  32; wb_exc  out  1: writeback handshake.
REQ-012 busy  out  1  high in any state other than IDLE; timeout_err  out  1  sticky abort flag.

Function
REQ-013 The FSM SHALL have four states: IDLE, LAUNCH, WAIT and WB.
REQ-014 IDLE behaviour: req_ready = 1. On req_valid & req_ready, latch op, a, b and rd, then go to LAUNCH.
REQ-015 LAUNCH lasts exactly one cycle: assert md_ctrl_MULT (op = 0) or md_ctrl_DIV (op = 1), clear the wait counter, then go to WAIT.
REQ-016 md_ctrl_MULT and md_ctrl_DIV SHALL be 0 in every state except LAUNCH and SHALL never be high together.
REQ-017 md_operandA/B SHALL present the latched operands, held unchanged from LAUNCH through the WB exit; the unit re-reads live operands for sign and exception logic.
REQ-018 md_resultRDY SHALL be ignored in IDLE, LAUNCH and WB; it is honoured only in WAIT.
REQ-019 WAIT behaviour: the counter increments each cycle. When md_resultRDY = 1, capture the result and go to WB, so wb_valid rises the cycle after RDY is sampled.
REQ-020 Capture, no exception: wb_rd = latched rd, wb_data = md_result, wb_exc = 0.
REQ-021 Capture, md_exception = 1: wb_rd = RSTATUS_REG, wb_data = MULT_EXC_CODE or DIV_EXC_CODE per op, wb_exc = 1.
REQ-022 Timeout: if the counter reaches TIMEOUT with no RDY, go to WB with wb_rd = 0, wb_data = 0, wb_exc = 1, and set timeout_err.
REQ-023 timeout_err SHALL stay set until reset.
REQ-024 RDY arriving in the same cycle the counter reaches TIMEOUT is treated as a normal capture, with no timeout.
REQ-025 WB behaviour: wb_valid = 1 and wb_* held stable until wb_ready = 1; on handshake go to IDLE. req_ready = 0 in WB, so there is no same-cycle accept.
REQ-026 The counter SHALL be 6 bits and saturate; it SHALL not wrap inside WAIT.
REQ-027 Each accepted request SHALL produce exactly one writeback.

Reset
REQ-028 While reset = 0 at a clock edge: state = IDLE; req_ready = 1; busy, wb_valid, wb_exc, timeout_err, md_ctrl_MULT, md_ctrl_DIV = 0; wb_rd, wb_data, md_operandA/B, counter = 0.
REQ-029 Reset mid-operation SHALL abort the operation with no writeback; a late md_resultRDY after reset SHALL be ignored (the controller is in IDLE).

Verification
REQ-030 Mult: op=0, a=7, b=-3, rd=9 -> one-cycle md_ctrl_MULT pulse; wb_valid with wb_rd=9, wb_data=0xFFFFFFEB, wb_exc=0.
REQ-031 Div: op=1, a=20, b=-3, rd=4 -> md_ctrl_DIV pulse; wb_rd=4, wb_data=0xFFFFFFFA. Also a=0x80000000 held stable across WAIT.
REQ-032 Exceptions: div with b=0 -> wb_rd=30, wb_data=5, wb_exc=1. Mult 0x00010000*0x00010000 -> wb_rd=30, wb_data=4, wb_exc=1.
REQ-033 Backpressure: hold wb_ready=0 for 10 cycles -> wb_* stable, req_ready=0, no new md_ctrl pulse; release -> IDLE next cycle.
REQ-034 Timeout: md_resultRDY forced 0 -> after 48 WAIT cycles wb_rd=0, wb_data=0, wb_exc=1; timeout_err=1 until reset.
REQ-035 Reset in WAIT cycle 10, then md_resultRDY=1 -> no wb_valid; all outputs at reset values; next request completes normally.
